// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line-level constants.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} uart_state_t;
`endif

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period counter: bit_done pulses for one cycle at the end of each
// CLKS_PER_BIT-cycle bit; restart clears the count.
module uart_baud_timer #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic bit_done
);

  localparam int unsigned WIDTH = $clog2(CLKS_PER_BIT);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(CLKS_PER_BIT - 1);

  logic [WIDTH-1:0] count_reg;

  assign bit_done = enable && !restart && (count_reg == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (restart || bit_done) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 (8E1 when UART_TX_PARITY_EN is defined), with a
// one-entry holding buffer in front of the shift register.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t          state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] buffer_reg;
  logic [DATA_BITS-1:0] load_data;
  logic                 buffer_full_reg, buffer_full_next;
  logic [2:0]           bit_index_reg, bit_index_next;
  logic                 tx_reg, tx_next;
  logic                 bit_done, accept, load, consume, bypass;
`ifdef UART_TX_PARITY_EN
  logic                 parity_reg;
`endif

  uart_baud_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (state_reg == IDLE),
    .enable  (state_reg != IDLE),
    .bit_done(bit_done)
  );

  assign accept    = tx_valid && !buffer_full_reg;
  assign load_data = buffer_full_reg ? buffer_reg : tx_data;

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_index_next = bit_index_reg;
    tx_next        = tx_reg;
    load           = 1'b0;
    consume        = 1'b0;
    bypass         = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next = IDLE_LEVEL;
        if (buffer_full_reg) begin
          state_next = START;
          load       = 1'b1;
          consume    = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_next     = DATA;
          bit_index_next = '0;
          tx_next        = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_index_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = parity_reg;
`else
            state_next = STOP;
            tx_next    = STOP_LEVEL;
`endif
          end else begin
            bit_index_next = bit_index_reg + 3'd1;
            shift_next     = shift_reg >> 1;
            tx_next        = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_next = STOP;
          tx_next    = STOP_LEVEL;
        end
      end
`endif
      STOP: begin
        // A byte offered on the last stop cycle goes straight into the shifter
        // so back-to-back frames never leave an idle gap.
        if (bit_done) begin
          if (buffer_full_reg) begin
            state_next = START;
            load       = 1'b1;
            consume    = 1'b1;
          end else if (tx_valid) begin
            state_next = START;
            load       = 1'b1;
            bypass     = 1'b1;
          end else begin
            state_next = IDLE;
            tx_next    = IDLE_LEVEL;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (load) begin
      shift_next = load_data;
      tx_next    = START_LEVEL;
    end
  end

  always_comb begin
    buffer_full_next = buffer_full_reg;
    if (consume) begin
      buffer_full_next = 1'b0;
    end else if (accept && !bypass) begin
      buffer_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      shift_reg       <= '0;
      buffer_reg      <= '0;
      buffer_full_reg <= 1'b0;
      bit_index_reg   <= '0;
      tx_reg          <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_reg      <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      buffer_full_reg <= buffer_full_next;
      bit_index_reg   <= bit_index_next;
      tx_reg          <= tx_next;
      if (accept && !bypass) begin
        buffer_reg <= tx_data;
      end
`ifdef UART_TX_PARITY_EN
      if (load) begin
        parity_reg <= ^load_data;
      end
`endif
    end
  end

  assign tx       = tx_reg;
  assign tx_ready = !buffer_full_reg;
  assign tx_busy  = (state_reg != IDLE) || buffer_full_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level model checked every cycle plus literal frame
// patterns; a second instance runs with CLKS_PER_BIT=2.
module tb_uart_tx;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int F    = 11;
  localparam int LOW2 = 20;
  localparam logic [10:0] P55 = 11'b10010101010;
  localparam logic [10:0] P81 = 11'b10100000010;
  localparam logic [10:0] P96 = 11'b10100101100;
  localparam logic [10:0] P07 = 11'b11000001110;
  localparam logic [10:0] P03 = 11'b10000000110;
`else
  localparam int F    = 10;
  localparam int LOW2 = 18;
  localparam logic [10:0] P55 = 11'b01010101010;
  localparam logic [10:0] P81 = 11'b01100000010;
  localparam logic [10:0] P96 = 11'b01100101100;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, tx_busy;
  logic [7:0] tx_data2 = 8'h00;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, tx2, tx_busy2;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy)
  );

  uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2)
  );

  function automatic void chk(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endfunction

  // Frame model: each accepted byte becomes (start edge, data); the line level
  // is derived from the position inside the frame.
  typedef struct {
    int         s;
    logic [7:0] d;
  } frame_t;

  frame_t q[$];
  int     cyc = 0;
  int     buf_release = 0;
  int     prev_end = -1;
  int     m_t, m_s;
  logic   m_in_frame;
  logic   exp_tx = 1'b1, exp_ready = 1'b1, exp_busy = 1'b0;

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && F == 11) return ^d;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      buf_release = 0;
      prev_end    = -1;
      exp_tx      = 1'b1;
      exp_ready   = 1'b1;
      exp_busy    = 1'b0;
    end else begin
      cyc++;
      m_t = cyc;
      if (tx_valid && m_t > buf_release) begin
        if (m_t == prev_end) m_s = m_t;
        else m_s = (m_t + 1 > prev_end) ? m_t + 1 : prev_end;
        q.push_back('{m_s, tx_data});
        buf_release = m_s;
        prev_end    = m_s + F * N;
      end
      while (q.size() > 0 && m_t >= q[0].s + F * N) void'(q.pop_front());
      m_in_frame = (q.size() > 0) && (m_t >= q[0].s);
      exp_tx     = m_in_frame ? frame_bit(q[0].d, (m_t - q[0].s) / N) : 1'b1;
      exp_busy   = m_in_frame || (m_t < buf_release);
      exp_ready  = !(m_t < buf_release);
    end
  end

  always @(negedge clk) begin
    chk("model_tx", tx, exp_tx);
    chk("model_tx_ready", tx_ready, exp_ready);
    chk("model_tx_busy", tx_busy, exp_busy);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a byte and return 1 ns after the edge that accepted it.
  task automatic send(input logic [7:0] b);
    int waited;
    waited = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    while (!tx_ready && waited < 300) begin
      tick();
      waited++;
    end
    if (!tx_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: tx_ready got 0 expected 1 for byte %02h", b);
    end
    tick();
    tx_valid = 1'b0;
    $display("tx byte %02h accepted at %0t", b, $time);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (tx_busy && n < 500) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, tx_busy, 1'b0);
  endtask

  // Called 1 ns after the start-bit edge; samples the first cycle of each bit.
  task automatic check_frame(input string name, input logic [10:0] pat);
    for (int k = 0; k < F; k++) begin
      chk($sformatf("%s_bit%0d", name, k), tx, pat[k]);
      repeat (N) tick();
    end
    chk({name, "_busy_after"}, tx_busy, 1'b0);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("reset_tx", tx, 1'b1);
    chk("reset_ready", tx_ready, 1'b1);
    chk("reset_busy", tx_busy, 1'b0);

    // Single byte from idle.
    send(8'h55);
    chk("t1_ready_low", tx_ready, 1'b0);
    chk("t1_line_idle", tx, 1'b1);
    tick();
    check_frame("t1_55", P55);

    // Back-to-back with tx_valid held.
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    tick();
    $display("tx byte a5 accepted at %0t", $time);
    tx_data = 8'h3C;
    chk("t2_ready_after_accept", tx_ready, 1'b0);
    tick();
    chk("t2_ready_at_start", tx_ready, 1'b1);
    chk("t2_start_bit", tx, 1'b0);
    tick();
    $display("tx byte 3c accepted at %0t", $time);
    tx_valid = 1'b0;
    chk("t2_ready_second", tx_ready, 1'b0);
    repeat (F * N - 1) tick();
    chk("t2_no_gap", tx, 1'b0);
    chk("t2_ready_reload", tx_ready, 1'b1);
    repeat (F * N) tick();
    chk("t2_busy_end", tx_busy, 1'b0);

    // Byte offered exactly on the last stop cycle starts without a gap.
    send(8'hC3);
    tick();
    repeat (F * N - 1) tick();
    tx_valid = 1'b1;
    tx_data  = 8'h96;
    tick();
    tx_valid = 1'b0;
    $display("tx byte 96 accepted at %0t", $time);
    chk("bypass_ready", tx_ready, 1'b1);
    check_frame("bypass_96", P96);

    // Buffer full: 0xFF must wait for tx_ready.
    send(8'h5A);
    tick();
    tx_valid = 1'b1;
    tx_data  = 8'h33;
    tick();
    $display("tx byte 33 accepted at %0t", $time);
    tx_data = 8'hFF;
    chk("t3_full", tx_ready, 1'b0);
    repeat (5) tick();
    chk("t3_still_full", tx_ready, 1'b0);
    send(8'hFF);
    chk("t3_ff_buffered", tx_ready, 1'b0);
    wait_idle("t3");

    // Reset in data bit 3 of 0x0F with a byte buffered.
    send(8'h0F);
    tick();
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    tick();
    tx_valid = 1'b0;
    chk("t4_full_before_reset", tx_ready, 1'b0);
    repeat (16) tick();
    chk("t4_busy_before_reset", tx_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t4_reset_tx", tx, 1'b1);
    chk("t4_reset_ready", tx_ready, 1'b1);
    chk("t4_reset_busy", tx_busy, 1'b0);
    tx_valid = 1'b1;
    tx_data  = 8'h81;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    tick();
    tx_valid = 1'b0;
    $display("tx byte 81 accepted at %0t", $time);
    chk("t4_first_accept", tx_ready, 1'b0);
    tick();
    check_frame("t4_81", P81);

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    tick();
    check_frame("par_07", P07);
    send(8'h03);
    tick();
    check_frame("par_03", P03);
`endif

    // CLKS_PER_BIT=2 instance: 0x00.
    tx_valid2 = 1'b1;
    tx_data2  = 8'h00;
    tick();
    tx_valid2 = 1'b0;
    $display("tx2 byte 00 accepted at %0t", $time);
    chk("n2_pre_start", tx2, 1'b1);
    tick();
    for (int i = 0; i < LOW2; i++) begin
      chk($sformatf("n2_low%0d", i), tx2, 1'b0);
      tick();
    end
    chk("n2_stop0", tx2, 1'b1);
    tick();
    chk("n2_stop1", tx2, 1'b1);
    tick();
    chk("n2_done", tx_busy2, 1'b0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
